// File: rtl/pc_gen_unit_pkg.sv
// pc_gen_unit_pkg
//   Shared constants and types for the fetch-stage PC generator.
//   - PC_W_DEF            : default PC width in bits
//   - RESET_VEC_DEF       : default PC value at reset
//   - EXC_VEC_DEF         : default exception entry address
//   - redirect_src_e      : which source steers pc_f this cycle (NONE/BR/ERET/EXC),
//                           kept as a named signal so it is visible when debugging
//   - sel_redirect()      : fixed-priority encoder exc > eret > br
package pc_gen_unit_pkg;

  localparam int          PC_W_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    RSRC_NONE = 2'd0,
    RSRC_BR   = 2'd1,
    RSRC_ERET = 2'd2,
    RSRC_EXC  = 2'd3
  } redirect_src_e;

  function automatic redirect_src_e sel_redirect(input logic exc,
                                                 input logic eret,
                                                 input logic br);
    if (exc)       return RSRC_EXC;
    else if (eret) return RSRC_ERET;
    else if (br)   return RSRC_BR;
    else           return RSRC_NONE;
  endfunction

endpackage

// File: rtl/pc_gen_unit_pc_adder.sv
// pc_adder
//   Constant-increment PC adder, modulo 2^PC_W (carry-out discarded).
//   Parameters: PC_W (width), INC (increment in bytes)
//   Ports:
//     a  in  PC_W  operand
//     y  out PC_W  a + INC
module pc_adder #(
  parameter int PC_W = 32,
  parameter int INC  = 4
) (
  input  logic [PC_W-1:0] a,
  output logic [PC_W-1:0] y
);

  assign y = a + PC_W'(INC);

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   Fetch-stage PC generator. Holds the fetch PC, advances it under the
//   inst-SRAM / hazard handshake and applies exception, ERET and branch
//   redirects with fixed priority. A branch resolved while fetch cannot
//   advance is buffered and applied at the next advance.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     fetch_ready       inst SRAM accepts the current request
//     stall             hazard-unit stall of F/D
//     exc_valid         exception/interrupt committed -> EXC_VEC
//     eret_valid, epc   ERET committed -> epc
//     br_valid,
//     br_target         taken branch/jump resolved in D
//     req_valid         fetch request valid (1 from first edge after reset)
//     pc_f              current fetch PC
//     pc_plus4_f        pc_f + 4
//     pc_plus8_f        pc_f + 8 (link address)
//     redirect_pending  a buffered branch target is waiting
//     adel_f            pc_f misaligned (fetch address error flag)
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF),
  parameter int              STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [PC_W-1:0] epc,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic            req_valid,
  output logic [PC_W-1:0] pc_f,
  output logic [PC_W-1:0] pc_plus4_f,
  output logic [PC_W-1:0] pc_plus8_f,
  output logic            redirect_pending,
  output logic            adel_f
);

  logic            req_valid_reg;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            pend_valid_reg, pend_valid_next;
  logic [PC_W-1:0] pend_target_reg, pend_target_next;
  logic            advance;
  redirect_src_e   redirect_src;

  // Adder bank: index 0 = sequential step, 1 = +4, 2 = +8 (link).
  logic [PC_W-1:0] sum [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_adder
      localparam int INC = (gi == 0) ? STEP : ((gi == 1) ? 4 : 8);
      pc_adder #(
        .PC_W (PC_W),
        .INC  (INC)
      ) u_pc_adder (
        .a (pc_reg),
        .y (sum[gi])
      );
    end
  endgenerate

  assign advance      = req_valid_reg & fetch_ready & ~stall;
  assign redirect_src = sel_redirect(exc_valid, eret_valid, br_valid);

  always_comb begin
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    case (redirect_src)
      // Flushing redirects take effect regardless of the handshake and
      // drop any buffered branch, which belongs to the flushed stream.
      RSRC_EXC: begin
        pc_next         = EXC_VEC;
        pend_valid_next = 1'b0;
      end
      RSRC_ERET: begin
        pc_next         = epc;
        pend_valid_next = 1'b0;
      end
      // The youngest branch always wins; an older buffered one is superseded.
      RSRC_BR: begin
        if (advance) begin
          pc_next         = br_target;
          pend_valid_next = 1'b0;
        end else begin
          pend_valid_next  = 1'b1;
          pend_target_next = br_target;
        end
      end
      default: begin
        if (advance) begin
          if (pend_valid_reg) begin
            pc_next         = pend_target_reg;
            pend_valid_next = 1'b0;
          end else begin
            pc_next = sum[0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_reg   <= 1'b0;
      pc_reg          <= RESET_VEC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      req_valid_reg   <= 1'b1;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
    end
  end

  assign req_valid        = req_valid_reg;
  assign pc_f             = pc_reg;
  assign pc_plus4_f       = sum[1];
  assign pc_plus8_f       = sum[2];
  assign redirect_pending = pend_valid_reg;
  assign adel_f           = |pc_reg[1:0];

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit
//   Self-checking bench for pc_gen_unit. Each cycle pushes the expected
//   pc_f / redirect_pending onto a scoreboard queue as stimulus is driven,
//   then pops and compares once the DUT has taken the clock edge.
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready, stall, exc_valid, eret_valid, br_valid;
  logic [31:0] epc, br_target;
  logic        req_valid, redirect_pending, adel_f;
  logic [31:0] pc_f, pc_plus4_f, pc_plus8_f;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  exp_t sb_q[$];

  pc_gen_unit dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_ready      (fetch_ready),
    .stall            (stall),
    .exc_valid        (exc_valid),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .req_valid        (req_valid),
    .pc_f             (pc_f),
    .pc_plus4_f       (pc_plus4_f),
    .pc_plus8_f       (pc_plus8_f),
    .redirect_pending (redirect_pending),
    .adel_f           (adel_f)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, record expectation, take the edge, compare.
  task automatic cyc(input logic fr, input logic st, input logic exc,
                     input logic eret, input logic [31:0] e_pc,
                     input logic br, input logic [31:0] tgt,
                     input logic [31:0] exp_pc, input logic exp_pend);
    exp_t e;
    fetch_ready = fr;
    stall       = st;
    exc_valid   = exc;
    eret_valid  = eret;
    epc         = e_pc;
    br_valid    = br;
    br_target   = tgt;
    sb_q.push_back('{pc: exp_pc, pend: exp_pend});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("pc_f", pc_f, e.pc);
      check_val("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
      check_val("pc_plus4_f", pc_plus4_f, e.pc + 32'd4);
      check_val("pc_plus8_f", pc_plus8_f, e.pc + 32'd8);
      check_val("adel_f", {31'd0, adel_f}, {31'd0, |e.pc[1:0]});
      check_val("req_valid", {31'd0, req_valid}, 32'd1);
      $display("cyc fr=%0d st=%0d exc=%0d eret=%0d br=%0d tgt=%08h -> pc_f=%08h pend=%0d",
               fr, st, exc, eret, br, tgt, pc_f, redirect_pending);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_pc_f", pc_f, 32'hBFC0_0000);
    check_val("rst_plus4", pc_plus4_f, 32'hBFC0_0004);
    check_val("rst_plus8", pc_plus8_f, 32'hBFC0_0008);
    check_val("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check_val("rst_pending", {31'd0, redirect_pending}, 32'd0);
    check_val("rst_adel", {31'd0, adel_f}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_ready = 1'b0; stall = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
    br_valid = 1'b0; epc = '0; br_target = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    // Reset release: first edge raises req_valid, then sequential fetch.
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 0);

    // Branch while advancing.
    cyc(1, 0, 0, 0, 0, 1, 32'h8000_0100, 32'h8000_0100, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'h8000_0104, 0);

    // Branch during a 3-cycle stall is buffered, applied on first advance.
    cyc(1, 1, 0, 0, 0, 1, 32'h8000_0200, 32'h8000_0104, 1);
    cyc(1, 1, 0, 0, 0, 0, 0,             32'h8000_0104, 1);
    cyc(1, 1, 0, 0, 0, 0, 0,             32'h8000_0104, 1);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'h8000_0200, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'h8000_0204, 0);

    // SRAM not ready buffers too; a newer branch overwrites the pending one;
    // an exception during the stall flushes it.
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0300, 32'h8000_0204, 1);
    cyc(1, 1, 0, 0, 0, 1, 32'h8000_0400, 32'h8000_0204, 1);
    cyc(1, 1, 1, 0, 0, 0, 0,             32'hBFC0_0380, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'hBFC0_0384, 0);

    // Overwrite check: newer pending target is the one applied.
    cyc(1, 1, 0, 0, 0, 1, 32'h8000_0800, 32'hBFC0_0384, 1);
    cyc(1, 1, 0, 0, 0, 1, 32'h8000_0900, 32'hBFC0_0384, 1);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'h8000_0900, 0);

    // Exception + branch together while stalled: branch discarded.
    cyc(1, 1, 1, 0, 0, 1, 32'h8000_0500, 32'hBFC0_0380, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'hBFC0_0384, 0);

    // ERET + branch together, while stalled: ERET wins regardless of advance.
    cyc(1, 1, 0, 1, 32'h8000_0010, 1, 32'h8000_0600, 32'h8000_0010, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,                         32'h8000_0014, 0);

    // Wraparound at the top of the address space.
    cyc(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'h0000_0000, 0);

    // Misaligned target loads unchanged and raises adel_f.
    cyc(1, 0, 0, 0, 0, 1, 32'h8000_0102, 32'h8000_0102, 0);
    cyc(1, 0, 0, 0, 0, 0, 0,             32'h8000_0106, 0);

    // Pending branch discarded by an asynchronous reset mid-stall.
    cyc(1, 1, 0, 0, 0, 1, 32'h8000_0700, 32'h8000_0106, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
